sipo_byte_assembler: RTL and testbench
======================================

// Module: sipo_byte_assembler
// PURPOSE
//  Serial-in/parallel-out front end that feeds the 8-bit register stage.
//  Collects WIDTH serial bits, plus an optional parity bit, into a word.
//  Presents the word on OUT with a VALID/READY handshake.
//  The downstream register loads OUT when VALID && READY.
// PARAMETERS
//  WIDTH      8  data bits per frame (>=2)
//  MSB_FIRST  0  0: first bit lands in OUT[0]; 1: first bit lands in OUT[WIDTH-1]
//  PARITY_EN  1  1: one parity bit follows the data bits
//  PARITY_ODD 0  0: even parity expected; 1: odd parity expected
// PORTS
//  CLK    in   1      rising-edge clock
//  CLRn   in   1      asynchronous active-low reset
//  START  in   1      frame-start pulse, sampled on CLK
//  SEN    in   1      sample enable; SIN is taken on an edge only when SEN=1
//  SIN    in   1      serial data bit
//  READY  in   1      downstream accepts OUT this cycle
//  OUT    out  WIDTH  assembled word; stable while VALID=1
//  VALID  out  1      OUT holds a complete frame
//  PERR   out  1      parity mismatch on current frame; meaningful while VALID=1
//  OVR    out  1      sticky overrun flag
//  BUSY   out  1      high in SHIFT or PAR
// BEHAVIOUR
//  Reset (CLRn=0, asynchronous): state=IDLE; OUT, VALID, PERR, OVR, BUSY, bit count all 0.
//  Reset has immediate effect mid-frame. No partial word is ever presented.
//  FSM states: IDLE, SHIFT, PAR, HOLD. All outputs are registered.
//  IDLE:
//   - START=1 -> SHIFT; clear shift register and count. SEN/SIN are ignored on that edge.
//  SHIFT:
//   - Each edge with SEN=1 shifts SIN in and increments count.
//   - When the WIDTH-th bit is taken: PARITY_EN=1 -> PAR; otherwise -> HOLD, with OUT loaded and VALID=1.
//   - START=1 in SHIFT aborts the frame and restarts it (count=0); START takes priority over SEN.
//  PAR:
//   - First edge with SEN=1 samples the parity bit.
//   - PERR = ^{data,SIN} ^ PARITY_ODD, i.e. 1 on mismatch.
//   - -> HOLD; OUT loaded; VALID=1.
//   - START=1 in PAR aborts the frame, as in SHIFT.
//  Latency: VALID rises on the edge that samples the last data bit (no parity) or the parity bit.
//  HOLD:
//   - VALID=1; OUT and PERR frozen.
//   - READY=1: transfer completes on that edge; VALID=0 on the next cycle. Go to IDLE, or to SHIFT if START=1 on the same edge.
//   - START=1 with READY=0: start is dropped, OVR set to 1, stay in HOLD.
//   - SEN/SIN are ignored in HOLD.
//  OVR clears only on reset or on the next successful transfer (VALID && READY).
//  A successful transfer that coincides with a dropped start is not possible, because a start in HOLD with READY=1 is honoured.
//  PERR is 0 whenever PARITY_EN=0. PERR clears when the next frame starts.
//  SEN gaps of any length are legal in SHIFT and PAR; no timeout.
//  Bit count width = clog2(WIDTH+1); the count never wraps, because the FSM exits at WIDTH.
// STRUCTURE
//  Shared package/include exp5_defs:
//   - state encodings ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_PAR=2'd2, ST_HOLD=2'd3
//   - default WIDTH constant
//  One sub-module, bit_counter:
//   - async active-low clear, sync clear, enable, terminal-count output at WIDTH-1
//  Shift register and parity accumulator live in the top module.
// TESTING
//  1 Reset: CLRn=0 mid-SHIFT after 3 bits -> all outputs 0 immediately; after release, idle with VALID=0.
//  2 Basic frame, LSB first, even parity:
//    START, then SEN with bits 1,0,1,1,0,0,1,0 and parity 0
//    -> OUT=8'h4D, VALID=1 the cycle after the parity edge, PERR=0; READY=1 -> VALID=0 next cycle.
//  3 Parity error: same frame with parity bit 1 -> OUT=8'h4D, PERR=1.
//  4 MSB_FIRST=1, PARITY_EN=0: bits 1,0,1,0,0,1,0,1 -> OUT=8'hA5; VALID on the 8th SEN edge.
//  5 Back-pressure and overrun:
//    - hold READY=0 with VALID=1, pulse START -> OVR=1, OUT unchanged.
//    - READY=1 -> VALID=0, OVR=0.
//  6 Abort and back-to-back:
//    - START after 5 bits -> next 8 bits form the word.
//    - START coincident with READY in HOLD -> new frame is accepted with no idle cycle.

Source files
------------

// File: rtl/sipo_byte_assembler_pkg.sv
// Shared definitions for the serial-to-parallel word assembler.
// The FSM encodings are fixed because they appear on the debug state port.
package exp5_defs;

  localparam int DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_PAR   = 2'd2,
    ST_HOLD  = 2'd3
  } state_e;

endpackage

// File: rtl/sipo_byte_assembler_bit_counter.sv
// Data-bit counter for the assembler. tc_o flags the bit that completes a word,
// so the FSM leaves SHIFT on that edge and the count never reaches a wrap.
module bit_counter
  import exp5_defs::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  localparam int CW   = $clog2(WIDTH + 1)
) (
  input  logic          clk_i,
  input  logic          clr_n_i,
  input  logic          sync_clr_i,
  input  logic          en_i,
  output logic [CW-1:0] count_o,
  output logic          tc_o
);

  logic [CW-1:0] count_q;

  always_ff @(posedge clk_i or negedge clr_n_i) begin
    if (!clr_n_i) begin
      count_q <= '0;
    end else if (sync_clr_i) begin
      count_q <= '0;
    end else if (en_i) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count_o = count_q;
  assign tc_o    = (count_q == CW'(WIDTH - 1));

endmodule

// File: rtl/sipo_byte_assembler.sv
// Serial-in/parallel-out word assembler with optional parity and a registered
// VALID/READY output stage. STATE_DBG exposes the FSM state for debug.
//
// Handshake: OUT/PERR are stable while VALID=1; a transfer happens on every
// rising edge where VALID && READY, and VALID drops on the following cycle.
module sipo_byte_assembler
  import exp5_defs::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter bit MSB_FIRST  = 1'b0,
  parameter bit PARITY_EN  = 1'b1,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic             CLK,
  input  logic             CLRn,
  input  logic             START,
  input  logic             SEN,
  input  logic             SIN,
  input  logic             READY,
  output logic [WIDTH-1:0] OUT,
  output logic             VALID,
  output logic             PERR,
  output logic             OVR,
  output logic             BUSY,
  output state_e           STATE_DBG
);

  localparam int CW = $clog2(WIDTH + 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             par_q, par_d;
  logic             valid_q, valid_d;
  logic             perr_q, perr_d;
  logic             ovr_q, ovr_d;
  logic             busy_q, busy_d;
  logic             start_frame;
  logic             cnt_en;
  logic             cnt_tc;
  logic [WIDTH-1:0] shift_in;

  bit_counter #(.WIDTH(WIDTH)) u_bit_counter (
    .clk_i      (CLK),
    .clr_n_i    (CLRn),
    .sync_clr_i (start_frame),
    .en_i       (cnt_en),
    .count_o    (),
    .tc_o       (cnt_tc)
  );

  // LSB-first shifts right so the first bit ends up in bit 0 after WIDTH shifts.
  assign shift_in = MSB_FIRST ? {shreg_q[WIDTH-2:0], SIN} : {SIN, shreg_q[WIDTH-1:1]};

  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    out_d       = out_q;
    par_d       = par_q;
    valid_d     = valid_q;
    perr_d      = perr_q;
    ovr_d       = ovr_q;
    start_frame = 1'b0;
    cnt_en      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (START) start_frame = 1'b1;
      end
      ST_SHIFT: begin
        if (START) begin
          start_frame = 1'b1;
        end else if (SEN) begin
          shreg_d = shift_in;
          par_d   = par_q ^ SIN;
          cnt_en  = 1'b1;
          if (cnt_tc) begin
            if (PARITY_EN) begin
              state_d = ST_PAR;
            end else begin
              state_d = ST_HOLD;
              out_d   = shift_in;
              valid_d = 1'b1;
              perr_d  = 1'b0;
            end
          end
        end
      end
      ST_PAR: begin
        if (START) begin
          start_frame = 1'b1;
        end else if (SEN) begin
          state_d = ST_HOLD;
          out_d   = shreg_q;
          perr_d  = par_q ^ SIN ^ PARITY_ODD;
          valid_d = 1'b1;
        end
      end
      ST_HOLD: begin
        if (READY) begin
          state_d = ST_IDLE;
          valid_d = 1'b0;
          ovr_d   = 1'b0;
          if (START) start_frame = 1'b1;
        end else if (START) begin
          ovr_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Any honoured start discards the partial word and begins a fresh frame.
    if (start_frame) begin
      state_d = ST_SHIFT;
      shreg_d = '0;
      par_d   = 1'b0;
      perr_d  = 1'b0;
    end

    busy_d = (state_d == ST_SHIFT) || (state_d == ST_PAR);
  end

  always_ff @(posedge CLK or negedge CLRn) begin
    if (!CLRn) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      out_q   <= '0;
      par_q   <= 1'b0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ovr_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      out_q   <= out_d;
      par_q   <= par_d;
      valid_q <= valid_d;
      perr_q  <= perr_d;
      ovr_q   <= ovr_d;
      busy_q  <= busy_d;
    end
  end

  assign OUT       = out_q;
  assign VALID     = valid_q;
  assign PERR      = perr_q;
  assign OVR       = ovr_q;
  assign BUSY      = busy_q;
  assign STATE_DBG = state_q;

endmodule

// File: tb/tb_sipo_byte_assembler.sv
// Directed bench for sipo_byte_assembler: dut_a uses default parameters
// (LSB first, even parity), dut_b is MSB first without parity.
module tb_sipo_byte_assembler;
  import exp5_defs::*;

  logic       clk;
  logic       clrn;
  logic       start_a, sen_a, sin_a, ready_a;
  logic       start_b, sen_b, sin_b, ready_b;
  logic [7:0] out_a, out_b;
  logic       valid_a, perr_a, ovr_a, busy_a;
  logic       valid_b, perr_b, ovr_b, busy_b;
  state_e     dbg_a, dbg_b;

  int checks = 0;
  int errors = 0;

  // Scoreboard entries are {expected PERR, expected OUT}.
  logic [8:0] exp_q[$];

  sipo_byte_assembler dut_a (
    .CLK(clk), .CLRn(clrn), .START(start_a), .SEN(sen_a), .SIN(sin_a), .READY(ready_a),
    .OUT(out_a), .VALID(valid_a), .PERR(perr_a), .OVR(ovr_a), .BUSY(busy_a), .STATE_DBG(dbg_a)
  );

  sipo_byte_assembler #(.WIDTH(8), .MSB_FIRST(1'b1), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) dut_b (
    .CLK(clk), .CLRn(clrn), .START(start_b), .SEN(sen_b), .SIN(sin_b), .READY(ready_b),
    .OUT(out_b), .VALID(valid_b), .PERR(perr_b), .OVR(ovr_b), .BUSY(busy_b), .STATE_DBG(dbg_b)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench did not finish");
  end

  // driver tasks
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic get_valid(input int sel);
    return (sel == 0) ? valid_a : valid_b;
  endfunction

  task automatic set_inputs(input int sel, input logic st, input logic se, input logic si, input logic rd);
    if (sel == 0) begin
      start_a = st; sen_a = se; sin_a = si; ready_a = rd;
    end else begin
      start_b = st; sen_b = se; sin_b = si; ready_b = rd;
    end
  endtask

  task automatic pulse_start(input int sel);
    set_inputs(sel, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc();
    set_inputs(sel, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // One serial bit, sometimes preceded by an idle SEN gap.
  task automatic send_bit(input int sel, input logic b);
    if ($urandom_range(0, 3) == 0) begin
      set_inputs(sel, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc();
    end
    set_inputs(sel, 1'b0, 1'b1, b, 1'b0);
    cyc();
    set_inputs(sel, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Sends seq[0] first; pushes the independently modelled result.
  task automatic send_frame(input int sel, input logic [7:0] seq, input logic pbit, input bit use_par);
    logic [7:0] word;
    logic       perr;
    for (int i = 0; i < 8; i++) begin
      if (i == 7 && !use_par) chk("pre_last_valid", 32'(get_valid(sel)), 32'd0);
      send_bit(sel, seq[i]);
    end
    if (use_par) begin
      chk("pre_par_valid", 32'(get_valid(sel)), 32'd0);
      send_bit(sel, pbit);
    end
    for (int i = 0; i < 8; i++) word[i] = (sel == 0) ? seq[i] : seq[7 - i];
    perr = use_par ? (^seq ^ pbit) : 1'b0;
    exp_q.push_back({perr, word});
  endtask

  // scoreboard: pop and compare the word currently presented
  task automatic check_pop(input int sel, input string tag);
    logic [8:0] e;
    chk({tag, "_valid"}, 32'(get_valid(sel)), 32'd1);
    if (exp_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_out"}, 32'((sel == 0) ? out_a : out_b), 32'(e[7:0]));
      chk({tag, "_perr"}, 32'((sel == 0) ? perr_a : perr_b), 32'(e[8]));
    end
  endtask

  task automatic accept(input int sel, input string tag);
    set_inputs(sel, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc();
    set_inputs(sel, 1'b0, 1'b0, 1'b0, 1'b0);
    chk({tag, "_valid_after_ready"}, 32'(get_valid(sel)), 32'd0);
  endtask

  initial begin
    logic [7:0] seq;
    clrn = 1'b0;
    set_inputs(0, 1'b0, 1'b0, 1'b0, 1'b0);
    set_inputs(1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc();
    cyc();
    chk("rst_valid", 32'(valid_a), 32'd0);
    chk("rst_out", 32'(out_a), 32'd0);
    clrn = 1'b1;
    cyc();

    // Asynchronous reset in the middle of a frame.
    pulse_start(0);
    send_bit(0, 1'b1);
    send_bit(0, 1'b0);
    send_bit(0, 1'b1);
    chk("mid_busy", 32'(busy_a), 32'd1);
    chk("mid_state", 32'(dbg_a), 32'(ST_SHIFT));
    #2 clrn = 1'b0;
    #1;
    chk("arst_busy", 32'(busy_a), 32'd0);
    chk("arst_valid", 32'(valid_a), 32'd0);
    chk("arst_ovr", 32'(ovr_a), 32'd0);
    chk("arst_perr", 32'(perr_a), 32'd0);
    chk("arst_state", 32'(dbg_a), 32'(ST_IDLE));
    cyc();
    clrn = 1'b1;
    cyc();
    chk("post_rst_valid", 32'(valid_a), 32'd0);
    chk("post_rst_state", 32'(dbg_a), 32'(ST_IDLE));

    // Basic frame 0x4D, good parity.
    pulse_start(0);
    send_frame(0, 8'h4D, 1'b0, 1'b1);
    chk("basic_busy", 32'(busy_a), 32'd0);
    check_pop(0, "basic");
    accept(0, "basic");

    // Same frame, wrong parity bit.
    pulse_start(0);
    send_frame(0, 8'h4D, 1'b1, 1'b1);
    check_pop(0, "perr");
    accept(0, "perr");

    // MSB first, no parity: 0xA5 on the eighth SEN edge.
    pulse_start(1);
    seq = 8'hA5;
    send_frame(1, seq, 1'b0, 1'b0);
    check_pop(1, "msb");
    accept(1, "msb");

    // Back-pressure and overrun.
    pulse_start(0);
    seq = 8'($urandom_range(0, 255));
    send_frame(0, seq, 1'($urandom_range(0, 1)), 1'b1);
    cyc();
    cyc();
    chk("bp_valid", 32'(valid_a), 32'd1);
    chk("bp_ovr_pre", 32'(ovr_a), 32'd0);
    set_inputs(0, 1'b1, 1'b1, 1'b1, 1'b0);
    cyc();
    set_inputs(0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("ovr_set", 32'(ovr_a), 32'd1);
    chk("ovr_state", 32'(dbg_a), 32'(ST_HOLD));
    chk("ovr_out_kept", 32'(out_a), 32'(exp_q[0][7:0]));
    cyc();
    chk("ovr_sticky", 32'(ovr_a), 32'd1);
    check_pop(0, "bp");
    accept(0, "bp");
    chk("ovr_cleared", 32'(ovr_a), 32'd0);

    // Abort after 5 bits; START wins over a coincident SEN.
    pulse_start(0);
    for (int i = 0; i < 5; i++) send_bit(0, 1'($urandom_range(0, 1)));
    set_inputs(0, 1'b1, 1'b1, 1'b1, 1'b0);
    cyc();
    set_inputs(0, 1'b0, 1'b0, 1'b0, 1'b0);
    seq = 8'($urandom_range(0, 255));
    send_frame(0, seq, 1'b0, 1'b1);
    check_pop(0, "abort");

    // START together with READY in HOLD: new frame with no idle cycle.
    set_inputs(0, 1'b1, 1'b0, 1'b0, 1'b1);
    cyc();
    set_inputs(0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("b2b_valid", 32'(valid_a), 32'd0);
    chk("b2b_busy", 32'(busy_a), 32'd1);
    chk("b2b_state", 32'(dbg_a), 32'(ST_SHIFT));
    chk("b2b_perr_clr", 32'(perr_a), 32'd0);
    seq = 8'($urandom_range(0, 255));
    send_frame(0, seq, 1'($urandom_range(0, 1)), 1'b1);
    check_pop(0, "b2b");
    accept(0, "b2b");
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
